// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the RV32I core writeback path:
//                writeback source selector and load funct3 encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Writeback source selector carried down the pipeline
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    // Load size / sign encodings in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage : core_pkg
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load data aligner. Picks the byte/half/word
//                addressed by the low address bits, sign- or zero-extends it,
//                and flags misaligned or undefined load encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data,
    output logic             fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection: byte lane by full offset, half lane by offset[1]
    always_comb begin
        w_byte = word[{offset, 3'b000} +: 8];
        w_half = word[{offset[1], 4'b0000} +: 16];
    end

    // Extension and fault classification by load type
    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            F3_LB: begin
                data = {{(WIDTH-8){w_byte[7]}}, w_byte};
            end
            F3_LBU: begin
                data = {{(WIDTH-8){1'b0}}, w_byte};
            end
            F3_LH: begin
                data  = {{(WIDTH-16){w_half[15]}}, w_half};
                fault = offset[0];
            end
            F3_LHU: begin
                data  = {{(WIDTH-16){1'b0}}, w_half};
                fault = offset[0];
            end
            F3_LW: begin
                data  = word;
                fault = (offset != 2'b00);
            end
            default: begin
                // 011, 110, 111 are not loads in RV32I
                data  = '0;
                fault = 1'b1;
            end
        endcase
    end

endmodule : load_align
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM/WB pipeline register and writeback unit. Captures MEM
//                results, aligns load data, selects the writeback value that
//                feeds the (negedge-writing) register file, and counts retired
//                instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import core_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int DEPTH  = 32,
    parameter  int CNT_W  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              M_VALID,
    input  logic              M_REGWRITE,
    input  logic [ADDR_W-1:0] M_RD,
    input  logic [1:0]        M_WB_SEL,
    input  logic [2:0]        M_FUNCT3,
    input  logic [WIDTH-1:0]  M_ALU_RESULT,
    input  logic [WIDTH-1:0]  M_LOAD_DATA,
    input  logic [WIDTH-1:0]  M_PC_PLUS4,
    input  logic [WIDTH-1:0]  M_IMM,
    output logic              REGWRITE,
    output logic [ADDR_W-1:0] ADR_WR_REG,
    output logic [WIDTH-1:0]  WR_DATA,
    output logic              WB_VALID,
    output logic              LOAD_FAULT,
    output logic [CNT_W-1:0]  INSTRET
);

    logic              r_valid;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_rd;
    wb_sel_e           r_wb_sel;
    logic [2:0]        r_funct3;
    logic [WIDTH-1:0]  r_alu;
    logic [WIDTH-1:0]  r_load;
    logic [WIDTH-1:0]  r_pc4;
    logic [WIDTH-1:0]  r_imm;
    logic [CNT_W-1:0]  r_instret;

    logic [WIDTH-1:0]  w_load_data;
    logic              w_align_fault;
    logic              w_load_fault;

    // Pipeline register: flush inserts a bubble even when stalled
    always_ff @(posedge clk) begin
        if (rst || FLUSH) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_wb_sel   <= WB_ALU;
            r_funct3   <= '0;
            r_alu      <= '0;
            r_load     <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
        end else if (!STALL) begin
            r_valid    <= M_VALID;
            r_regwrite <= M_REGWRITE;
            r_rd       <= M_RD;
            r_wb_sel   <= wb_sel_e'(M_WB_SEL);
            r_funct3   <= M_FUNCT3;
            r_alu      <= M_ALU_RESULT;
            r_load     <= M_LOAD_DATA;
            r_pc4      <= M_PC_PLUS4;
            r_imm      <= M_IMM;
        end
    end

    load_align #(
        .WIDTH (WIDTH)
    ) u_load_align (
        .word   (r_load),
        .offset (r_alu[1:0]),
        .funct3 (r_funct3),
        .data   (w_load_data),
        .fault  (w_align_fault)
    );

    // Fault only matters for a real instruction that writes back load data
    always_comb begin
        w_load_fault = r_valid && (r_wb_sel == WB_LOAD) && w_align_fault;
    end

    // Retire counter: counts on the edge where the instruction leaves the stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_valid && !w_load_fault && !STALL) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Writeback value selection; forced to zero for bubbles
    always_comb begin
        WR_DATA = '0;
        if (r_valid) begin
            case (r_wb_sel)
                WB_ALU:  WR_DATA = r_alu;
                WB_LOAD: WR_DATA = w_load_data;
                WB_PC4:  WR_DATA = r_pc4;
                WB_IMM:  WR_DATA = r_imm;
                default: WR_DATA = '0;
            endcase
        end
    end

    // Register file controls; x0 is never written and faulting loads are dropped
    always_comb begin
        REGWRITE   = r_valid && r_regwrite && (r_rd != '0) && !w_load_fault;
        ADR_WR_REG = r_rd;
        WB_VALID   = r_valid;
        LOAD_FAULT = w_load_fault;
        INSTRET    = r_instret;
    end

endmodule : mem_wb_stage
`default_nettype wire
